// File: rtl/sram_arbiter_pkg.sv
// Shared width helpers and per-port request control struct for the SRAM arbiter.
package sram_arbiter_pkg;

  function automatic int calc_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int calc_be_width(input int data_width, input int byte_width);
    return (data_width + byte_width - 1) / byte_width;
  endfunction

  typedef struct packed {
    logic valid;
    logic we;
  } req_ctrl_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans requests starting at ptr_i, returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IdxWidth = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [N-1:0]        gnt_o,
  output logic [IdxWidth-1:0] gnt_idx_o,
  output logic                valid_o
);

  int cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[IdxWidth'(cand)]) begin
        valid_o                 = 1'b1;
        gnt_o[IdxWidth'(cand)]  = 1'b1;
        gnt_idx_o               = IdxWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM among NumPorts requesters; reads return through a
// one-deep per-port response register, writes complete silently.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NumPorts  = 2,
  parameter int Depth     = 128,
  parameter int DataWidth = 128,
  parameter int ByteWidth = 8,
  localparam int AddrWidth   = calc_addr_width(Depth),
  localparam int ByteEnWidth = calc_be_width(DataWidth, ByteWidth)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPorts-1:0]                  req_valid_i,
  output logic [NumPorts-1:0]                  req_ready_o,
  input  logic [NumPorts-1:0]                  req_we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]   req_addr_i,
  input  logic [NumPorts-1:0][ByteEnWidth-1:0] req_be_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   req_wdata_i,
  output logic [NumPorts-1:0]                  rsp_valid_o,
  input  logic [NumPorts-1:0]                  rsp_ready_i,
  output logic [NumPorts-1:0][DataWidth-1:0]   rsp_rdata_o,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [AddrWidth-1:0]                 sram_addr_o,
  output logic [ByteEnWidth-1:0]               sram_be_o,
  output logic [DataWidth-1:0]                 sram_wdata_o,
  input  logic [DataWidth-1:0]                 sram_rdata_i
);

  localparam int PtrWidth = $clog2(NumPorts);

  logic [PtrWidth-1:0]                r_ptr;
  logic [NumPorts-1:0]                r_inflight;
  logic [NumPorts-1:0]                r_rsp_valid;
  logic [NumPorts-1:0][DataWidth-1:0] r_rsp_rdata;

  req_ctrl_t [NumPorts-1:0] w_req_ctrl;
  logic [NumPorts-1:0]      w_eligible;
  logic [NumPorts-1:0]      w_gnt;
  logic [NumPorts-1:0]      w_gnt_en;
  logic [PtrWidth-1:0]      w_gnt_idx;
  logic                     w_gnt_any;
  logic                     w_grant;

  // A read may only issue when its response slot is free or drains this cycle.
  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    assign w_req_ctrl[gi] = '{valid: req_valid_i[gi], we: req_we_i[gi]};
    assign w_eligible[gi] = w_req_ctrl[gi].valid &
                            (w_req_ctrl[gi].we |
                             (~r_inflight[gi] & (~r_rsp_valid[gi] | rsp_ready_i[gi])));

    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[gi] && !req_ready_o[gi]) |=>
        (req_valid_i[gi] && $stable(req_we_i[gi]) && $stable(req_addr_i[gi]) &&
         $stable(req_be_i[gi]) && $stable(req_wdata_i[gi])));
  end

  rr_arbiter #(
    .N(NumPorts)
  ) u_rr_arbiter (
    .req_i    (w_eligible),
    .ptr_i    (r_ptr),
    .gnt_o    (w_gnt),
    .gnt_idx_o(w_gnt_idx),
    .valid_o  (w_gnt_any)
  );

  assign w_grant  = rst_ni & w_gnt_any;
  assign w_gnt_en = w_gnt & {NumPorts{rst_ni}};

  assign req_ready_o  = w_gnt_en;
  assign sram_req_o   = w_grant;
  assign sram_we_o    = w_grant & req_we_i[w_gnt_idx];
  assign sram_addr_o  = req_addr_i[w_gnt_idx];
  assign sram_be_o    = req_be_i[w_gnt_idx];
  assign sram_wdata_o = req_wdata_i[w_gnt_idx];

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      if (w_gnt_idx == PtrWidth'(NumPorts - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_gnt_idx + 1'b1;
      end
    end
  end

  // SRAM data arrives the cycle after the read command, i.e. while inflight is set.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_inflight  <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_inflight <= w_gnt_en & ~req_we_i;
      for (int p = 0; p < NumPorts; p++) begin
        if (r_inflight[p]) begin
          r_rsp_valid[p] <= 1'b1;
          r_rsp_rdata[p] <= sram_rdata_i;
        end else if (rsp_ready_i[p]) begin
          r_rsp_valid[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and a per-port read scoreboard.
module tb_sram_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0][3:0]   req_addr;
  logic [1:0][3:0]   req_be;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [1:0][31:0]  rsp_rdata;
  logic              sram_req;
  logic              sram_we;
  logic [3:0]        sram_addr;
  logic [3:0]        sram_be;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  logic [31:0] sram_mem [16];
  logic [31:0] ref_mem  [16];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .NumPorts (2),
    .Depth    (16),
    .DataWidth(32),
    .ByteWidth(8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_be_i    (req_be),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .sram_req_o  (sram_req),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_be_o   (sram_be),
    .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: reference memory updated in grant order, reads queue their expected data.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p] && rsp_ready[p]) begin
          logic [31:0] e;
          if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            chk($sformatf("rsp_unexpected_p%0d", p), {31'b0, rsp_valid[p]}, 32'd0);
          end else begin
            if (p == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            chk($sformatf("rsp_data_p%0d", p), rsp_rdata[p], e);
          end
          $display("[TB] t=%0t rsp  p%0d data=0x%08h", $time, p, rsp_rdata[p]);
        end
        if (req_ready[p]) begin
          if (req_we[p]) begin
            for (int b = 0; b < 4; b++)
              if (req_be[p][b]) ref_mem[req_addr[p]][8*b +: 8] = req_wdata[p][8*b +: 8];
          end else if (p == 0) begin
            exp_q0.push_back(ref_mem[req_addr[p]]);
          end else begin
            exp_q1.push_back(ref_mem[req_addr[p]]);
          end
          $display("[TB] t=%0t gnt  p%0d we=%0b addr=%0d be=0x%0h wdata=0x%08h",
                   $time, p, req_we[p], req_addr[p], req_be[p], req_wdata[p]);
        end
      end
    end
  end

  // Raise a request, wait (bounded) for its grant, drop valid in the cycle after the grant.
  task automatic issue(input int p, input bit we, input logic [3:0] a, input logic [3:0] be,
                       input logic [31:0] d, input string tag);
    int n;
    n = 0;
    req_we[p] = we; req_addr[p] = a; req_be[p] = be; req_wdata[p] = d; req_valid[p] = 1'b1;
    @(negedge clk);
    while (!req_ready[p] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant"}, {31'b0, req_ready[p]}, 32'd1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  // Withdraw pending requests only once each has been granted.
  task automatic drain(input string tag);
    logic [1:0] g;
    for (int n = 0; n < 20 && req_valid != 2'b00; n++) begin
      @(negedge clk);
      g = req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
    end
    chk({tag, "_drain"}, {30'b0, req_valid}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0_cnt;
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    rst_n = 1'b0; req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_be = '0;
    req_wdata = '0; rsp_ready = 2'b11;

    // Reset: grants forced off, response state cleared.
    idle(3);
    @(negedge clk);
    chk("rst_ready",    {30'b0, req_ready}, 32'd0);
    chk("rst_sram_req", {31'b0, sram_req},  32'd0);
    chk("rst_rsp_valid",{30'b0, rsp_valid}, 32'd0);
    chk("rst_rdata0",   rsp_rdata[0], 32'd0);
    chk("rst_rdata1",   rsp_rdata[1], 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    idle(1);
    rst_n = 1'b1;
    idle(2);

    // Write then read back; response appears two cycles after the read grant.
    issue(0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF, "r36_wr");
    issue(0, 1'b0, 4'd3, 4'hF, 32'h0, "r36_rd");
    @(negedge clk);
    chk("r36_valid_t1", {31'b0, rsp_valid[0]}, 32'd0);
    @(posedge clk); #1;
    chk("r36_valid_t2", {31'b0, rsp_valid[0]}, 32'd1);
    chk("r36_rdata",    rsp_rdata[0], 32'hDEADBEEF);
    idle(2);

    // Byte-enable merge.
    issue(0, 1'b1, 4'd5, 4'hF, 32'h11223344, "r39_wr_full");
    issue(0, 1'b1, 4'd5, 4'h2, 32'h0000AA00, "r39_wr_byte");
    issue(0, 1'b0, 4'd5, 4'hF, 32'h0, "r39_rd");
    @(posedge clk); #1;
    chk("r39_valid", {31'b0, rsp_valid[0]}, 32'd1);
    chk("r39_rdata", rsp_rdata[0], 32'h1122AA44);
    idle(3);

    // Continuous reads from both ports; last grant went to P0 so P1 leads.
    req_we = 2'b00; req_addr[0] = 4'd3; req_addr[1] = 4'd5; req_be = '1; req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("r37_gnt%0d", k), {30'b0, req_ready}, (k % 2 == 0) ? 32'd2 : 32'd1);
      chk($sformatf("r37_sram_req%0d", k), {31'b0, sram_req}, 32'd1);
      @(posedge clk); #1;
    end
    drain("r37");
    idle(4);

    // Back-pressure on P1: its response holds and it gets no new read; P0 keeps going.
    rsp_ready = 2'b01;
    issue(1, 1'b0, 4'd3, 4'hF, 32'h0, "r38_rd");
    req_we = 2'b00; req_addr[0] = 4'd5; req_addr[1] = 4'd5; req_valid = 2'b11;
    @(posedge clk); #1;
    p0_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("r38_hold_valid%0d", k), {31'b0, rsp_valid[1]}, 32'd1);
      chk($sformatf("r38_hold_data%0d", k),  rsp_rdata[1], 32'hDEADBEEF);
      chk($sformatf("r38_no_gnt%0d", k),     {31'b0, req_ready[1]}, 32'd0);
      if (req_ready[0]) p0_cnt++;
      @(posedge clk); #1;
    end
    chk("r38_p0_served", {31'b0, p0_cnt >= 2}, 32'd1);
    rsp_ready = 2'b11;
    drain("r38");
    idle(4);

    // Reset the cycle after a read grant: the read is dropped and the pointer restarts.
    issue(0, 1'b0, 4'd5, 4'hF, 32'h0, "r40_rd");
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    idle(2);
    @(negedge clk);
    chk("r40_rst_valid", {30'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("r40_post_valid%0d", k), {30'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    req_we = 2'b00; req_addr[0] = 4'd3; req_addr[1] = 4'd3; req_valid = 2'b11;
    @(negedge clk);
    chk("r40_first_gnt", {30'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    drain("r40");

    idle(6);
    chk("sb_empty_p0", exp_q0.size(), 32'd0);
    chk("sb_empty_p1", exp_q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
